r5fp_postproc_arb: RTL and testbench

Round-robin arbiter and pipeline sequencer that lets N_REQ FP producers (adder, multiplier, divider, etc.) share one R5FP post-processing (rounding/packing) datapath instance.
- Accepts unrounded {aExp, aSig, aStatus, aSign, specialTiny, zToInf, rnd, tailZeroCnt} bundles over valid/ready handshakes.
- Registers the granted bundle into stage S1, which drives the shared datapath.
- Captures the datapath result in stage S2 and returns it with the requester index, under output backpressure.

---
 rtl/r5fp_postproc_arb.sv | 144 ++++++++++++++
 tb/tb_r5fp_postproc_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r5fp_postproc_arb.sv
`default_nettype none
// ============================================================================
// r5fp_postproc_arb: round-robin arbiter + 2-stage sequencer sharing one R5FP
// post-processing datapath among N_REQ producers.   Rev 1.0
// ============================================================================
module r5fp_postproc_arb #(
  parameter int I_SIG_W = 27,
  parameter int SIG_W   = 23,
  parameter int EXP_W   = 9,
  parameter int N_REQ   = 3,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*EXP_W-1:0]   req_aExp,
  input  logic [N_REQ*I_SIG_W-1:0] req_aSig,
  input  logic [N_REQ*6-1:0]       req_aStatus,
  input  logic [N_REQ-1:0]         req_aSign,
  input  logic [N_REQ-1:0]         req_specialTiny,
  input  logic [N_REQ-1:0]         req_zToInf,
  input  logic [N_REQ*3-1:0]       req_rnd,
  input  logic [N_REQ*EXP_W-1:0]   req_tailZeroCnt,
  output logic [EXP_W-1:0]         pp_aExp,
  output logic [I_SIG_W-1:0]       pp_aSig,
  output logic [5:0]               pp_aStatus,
  output logic                     pp_aSign,
  output logic                     pp_specialTiny,
  output logic                     pp_zToInf,
  output logic [2:0]               pp_rnd,
  output logic [EXP_W-1:0]         pp_tailZeroCnt,
  input  logic [SIG_W+EXP_W:0]     pp_z,
  input  logic [7:0]               pp_zStatus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIG_W+EXP_W:0]     out_z,
  output logic [7:0]               out_zStatus,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

  localparam int B_W = 2*EXP_W + I_SIG_W + 6 + 3 + 3;

  logic                          r_s1_valid;
  logic                          r_s2_valid;
  logic [ID_W-1:0]               r_s1_id;
  logic [ID_W-1:0]               r_last_grant;

  logic                          w_s1_ready;
  logic                          w_s2_ready;
  logic                          w_xfer;
  logic [ID_W:0]                 w_shamt;
  logic [ID_W:0]                 w_back;
  logic [N_REQ-1:0]              w_rot;
  logic [N_REQ-1:0]              w_seen;
  logic [N_REQ-1:0]              w_first;
  logic [N_REQ-1:0]              w_grant;
  logic [N_REQ-1:0][B_W-1:0]     w_bundle;
  logic [N_REQ:0][B_W-1:0]       w_sel_acc;
  logic [N_REQ:0][ID_W-1:0]      w_id_acc;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;

  // Rotate requests so bit 0 is the slot after last_grant, pick the lowest
  // set bit, then rotate the one-hot pick back to requester order.
  assign w_shamt = {1'b0, r_last_grant} + (ID_W+1)'(1);
  assign w_back  = (ID_W+1)'(N_REQ) - w_shamt;
  assign w_rot   = N_REQ'({req_valid, req_valid} >> w_shamt);
  assign w_grant = N_REQ'({w_first, w_first} >> w_back);

  assign w_sel_acc[0] = '0;
  assign w_id_acc[0]  = '0;

  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_prio
      if (k == 0) begin : g_first
        assign w_seen[k] = 1'b0;
      end else begin : g_rest
        assign w_seen[k] = w_seen[k-1] | w_rot[k-1];
      end
      assign w_first[k] = w_rot[k] & ~w_seen[k];
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign w_bundle[i] = {req_aExp[i*EXP_W +: EXP_W],
                            req_aSig[i*I_SIG_W +: I_SIG_W],
                            req_aStatus[i*6 +: 6],
                            req_aSign[i], req_specialTiny[i], req_zToInf[i],
                            req_rnd[i*3 +: 3],
                            req_tailZeroCnt[i*EXP_W +: EXP_W]};
      assign w_sel_acc[i+1] = w_sel_acc[i] | (w_bundle[i] & {B_W{w_grant[i]}});
      assign w_id_acc[i+1]  = w_id_acc[i] | (w_grant[i] ? ID_W'(i) : '0);
    end
  endgenerate

  // Reset is synchronous, so the combinational ready must be masked during it.
  assign req_ready = (w_s1_ready && !reset) ? w_grant : '0;
  assign w_xfer    = |req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid     <= 1'b0;
      r_s2_valid     <= 1'b0;
      r_s1_id        <= '0;
      r_last_grant   <= ID_W'(N_REQ-1);
      pp_aExp        <= '0;
      pp_aSig        <= '0;
      pp_aStatus     <= '0;
      pp_aSign       <= 1'b0;
      pp_specialTiny <= 1'b0;
      pp_zToInf      <= 1'b0;
      pp_rnd         <= '0;
      pp_tailZeroCnt <= '0;
      out_z          <= '0;
      out_zStatus    <= '0;
      out_id         <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= w_xfer;
        if (w_xfer) begin
          {pp_aExp, pp_aSig, pp_aStatus, pp_aSign, pp_specialTiny, pp_zToInf,
           pp_rnd, pp_tailZeroCnt} <= w_sel_acc[N_REQ];
          r_s1_id      <= w_id_acc[N_REQ];
          r_last_grant <= w_id_acc[N_REQ];
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out_z       <= pp_z;
          out_zStatus <= pp_zStatus;
          out_id      <= r_s1_id;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_r5fp_postproc_arb.sv
`default_nettype none
// Bench for r5fp_postproc_arb: cycle model of the handshake plus a result
// scoreboard fed by a toy post-processing datapath.
module tb_r5fp_postproc_arb;
  localparam int I_SIG_W = 27;
  localparam int SIG_W   = 23;
  localparam int EXP_W   = 9;
  localparam int N_REQ   = 3;
  localparam int ID_W    = 2;
  localparam int Z_W     = SIG_W + EXP_W + 1;
  localparam int ST_STICKY = 0;
  localparam int ST_ZERO   = 3;
  localparam logic [2:0] RND_UP = 3'b011;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*EXP_W-1:0]   req_aExp = '0;
  logic [N_REQ*I_SIG_W-1:0] req_aSig = '0;
  logic [N_REQ*6-1:0]       req_aStatus = '0;
  logic [N_REQ-1:0]         req_aSign = '0;
  logic [N_REQ-1:0]         req_specialTiny = '0;
  logic [N_REQ-1:0]         req_zToInf = '0;
  logic [N_REQ*3-1:0]       req_rnd = '0;
  logic [N_REQ*EXP_W-1:0]   req_tailZeroCnt = '0;
  logic [EXP_W-1:0]         pp_aExp;
  logic [I_SIG_W-1:0]       pp_aSig;
  logic [5:0]               pp_aStatus;
  logic                     pp_aSign;
  logic                     pp_specialTiny;
  logic                     pp_zToInf;
  logic [2:0]               pp_rnd;
  logic [EXP_W-1:0]         pp_tailZeroCnt;
  logic [Z_W-1:0]           pp_z;
  logic [7:0]               pp_zStatus;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [Z_W-1:0]           out_z;
  logic [7:0]               out_zStatus;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  r5fp_postproc_arb #(.I_SIG_W(I_SIG_W), .SIG_W(SIG_W), .EXP_W(EXP_W),
                      .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aExp(req_aExp), .req_aSig(req_aSig), .req_aStatus(req_aStatus),
    .req_aSign(req_aSign), .req_specialTiny(req_specialTiny),
    .req_zToInf(req_zToInf), .req_rnd(req_rnd),
    .req_tailZeroCnt(req_tailZeroCnt),
    .pp_aExp(pp_aExp), .pp_aSig(pp_aSig), .pp_aStatus(pp_aStatus),
    .pp_aSign(pp_aSign), .pp_specialTiny(pp_specialTiny),
    .pp_zToInf(pp_zToInf), .pp_rnd(pp_rnd), .pp_tailZeroCnt(pp_tailZeroCnt),
    .pp_z(pp_z), .pp_zStatus(pp_zStatus),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_zStatus(out_zStatus), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Toy rounding/packing stage; the scoreboard applies the same map to bundles.
  function automatic logic [Z_W+7:0] toy_pp(
      input logic [EXP_W-1:0] e, input logic [I_SIG_W-1:0] s,
      input logic [5:0] st, input logic sg, input logic tiny,
      input logic zinf, input logic [2:0] rnd, input logic [EXP_W-1:0] tz);
    logic [Z_W-1:0] z;
    z = {sg, e, s[I_SIG_W-1 -: SIG_W]} ^ Z_W'(tz);
    if (rnd == RND_UP && !sg && st[ST_STICKY]) z = z + 1'b1;
    return {{tiny, zinf, st} ^ {5'b0, rnd}, z};
  endfunction

  always_comb
    {pp_zStatus, pp_z} = toy_pp(pp_aExp, pp_aSig, pp_aStatus, pp_aSign,
                                pp_specialTiny, pp_zToInf, pp_rnd, pp_tailZeroCnt);

  function automatic logic [Z_W+7:0] req_result(input int i);
    return toy_pp(req_aExp[i*EXP_W +: EXP_W], req_aSig[i*I_SIG_W +: I_SIG_W],
                  req_aStatus[i*6 +: 6], req_aSign[i], req_specialTiny[i],
                  req_zToInf[i], req_rnd[i*3 +: 3],
                  req_tailZeroCnt[i*EXP_W +: EXP_W]);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [Z_W-1:0]  z;
    logic [7:0]      st;
    logic [ID_W-1:0] id;
  } exp_t;
  exp_t sb[$];

  bit m_s1, m_s2;
  int m_last = N_REQ - 1;

  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (v[idx]) return N_REQ'(1) << idx;
    end
    return '0;
  endfunction

  // Cycle model: inputs are stable at the falling edge, so the model checks
  // the current cycle and then advances to the state after the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", 64'(req_ready), 64'(0));
      m_s1 = 0; m_s2 = 0; m_last = N_REQ - 1;
      sb.delete();
    end else begin
      logic s1r, s2r;
      logic [N_REQ-1:0] g;
      chk("out_valid", 64'(out_valid), 64'(m_s2));
      chk("busy", 64'(busy), 64'(m_s1 | m_s2));
      if (m_s2 && sb.size() > 0) begin
        chk("out_z", 64'(out_z), 64'(sb[0].z));
        chk("out_zStatus", 64'(out_zStatus), 64'(sb[0].st));
        chk("out_id", 64'(out_id), 64'(sb[0].id));
        if (out_ready) void'(sb.pop_front());
      end
      s2r = !m_s2 || out_ready;
      s1r = !m_s1 || s2r;
      g = s1r ? rr_pick(req_valid, m_last) : '0;
      chk("req_ready", 64'(req_ready), 64'(g));
      if (s2r) m_s2 = m_s1;
      if (s1r) m_s1 = (g != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (g[i]) begin
          exp_t e;
          {e.st, e.z} = req_result(i);
          e.id = ID_W'(i);
          sb.push_back(e);
          m_last = i;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic rand_bundles();
    req_aExp        = N_REQ*EXP_W'($urandom);
    req_aSig        = {$urandom, $urandom, $urandom};
    req_aStatus     = N_REQ*6'($urandom);
    req_aSign       = N_REQ'($urandom);
    req_specialTiny = N_REQ'($urandom);
    req_zToInf      = N_REQ'($urandom);
    req_rnd         = N_REQ*3'($urandom);
    req_tailZeroCnt = N_REQ*EXP_W'($urandom);
  endtask

  initial begin
    int cnt;
    bit got;
    step();
    step();
    reset = 1'b0;

    // Single request from requester 1: zero + sticky rounded up -> smallest subnormal
    out_ready = 1'b1;
    rand_bundles();
    req_aExp[1*EXP_W +: EXP_W]         = '0;
    req_aSig[1*I_SIG_W +: I_SIG_W]     = '0;
    req_aStatus[1*6 +: 6]              = 6'((1 << ST_ZERO) | (1 << ST_STICKY));
    req_aSign[1]                       = 1'b0;
    req_rnd[1*3 +: 3]                  = RND_UP;
    req_tailZeroCnt[1*EXP_W +: EXP_W]  = '0;
    req_valid = 3'b010;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_lat1", 64'(out_valid), 64'(0));
    step();
    @(negedge clk);
    chk("t1_lat2", 64'(out_valid), 64'(1));
    chk("t1_z", 64'(out_z), 64'(33'h0_0000_0001));
    chk("t1_id", 64'(out_id), 64'(1));
    step();

    // All requesters continuously valid: strict 0,1,2 rotation
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t2_grant", 64'(req_ready), 64'(N_REQ'(1) << (k % N_REQ)));
      if (k >= 2) chk("t2_stream", 64'(out_valid), 64'(1));
      step();
      rand_bundles();
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure: only two bundles fit
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b001;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready[0]) cnt++;
      step();
      rand_bundles();
    end
    chk("t3_accepts", 64'(cnt), 64'(2));
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t3_idle", 64'(busy), 64'(0));

    // Drain and accept in the same cycle
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b100;
    repeat (3) step();
    @(negedge clk);
    chk("t4_full", 64'(req_ready), 64'(0));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_accept", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t4_nobubble", 64'(out_valid), 64'(1));
    repeat (3) step();

    // Reset with both stages full
    out_ready = 1'b0;
    req_valid = 3'b011;
    repeat (3) step();
    req_valid = '1;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_first", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    repeat (3) step();

    // Fairness: requester 2 joins a stream of requester 0
    do_reset();
    req_valid = 3'b001;
    repeat (2) step();
    req_valid = 3'b101;
    cnt = 0;
    got = 0;
    for (int k = 0; k < 2*N_REQ && !got; k++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1;
      else if (req_ready != 0) cnt++;
      step();
    end
    chk("t6_granted", 64'(got), 64'(1));
    chk("t6_wait", 64'(cnt <= N_REQ-1), 64'(1));
    req_valid = '1;
    @(negedge clk);
    chk("t6_after", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    repeat (3) step();

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      rand_bundles();
      req_valid = N_REQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
